mac_job_scheduler: RTL and testbench
====================================

# mac_job_scheduler

Shares the pipelined dot-product MAC accelerator among `NREQ` requesters. It arbitrates pending jobs round-robin, clears and starts the accelerator with the winner's vector length, and waits for end-of-computation. It then returns the captured sum to the owning requester. It sits between the requester ports and the accelerator's `go`/`N`/`eoc`/sum interface, and drives the operand-memory owner select.

## Interface
- `ID_W`, default 2: requester index width; `NREQ = 2**ID_W`.
- `LEN_W`, default 8: vector length width, matching the accelerator `N` register.
- `DATA_W`, default 16: accelerator sum width.
- `TMO_W`, default 10: timeout counter width.
- `TIMEOUT`, default 600: maximum RUN cycles before abort; must exceed worst-case accelerator latency.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester job request; level, held until `gnt`.
- `req_len`  in  NREQ*LEN_W  packed vector lengths; slice i sampled when requester i wins.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: job accepted.
- `done`  out  NREQ  one-hot, one-cycle pulse: result valid.
- `err`  out  1  valid with `done`; 1 = job aborted by timeout.
- `result`  out  DATA_W  job sum; updated with `done`, held until the next `done`.
- `busy`  out  1  high in every state except IDLE.
- `acc_clr`  out  1  one-cycle clear to the accelerator controllers.
- `acc_go`  out  1  one-cycle start to the accelerator.
- `acc_n`  out  LEN_W  length presented to the accelerator; held for the whole job.
- `acc_sel`  out  ID_W  current owner; steers the operand-memory mux.
- `acc_eoc`  in  1  accelerator end-of-computation, level.
- `acc_sum`  in  DATA_W  accelerator accumulator output.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, RR pointer 0, timeout counter 0.
- FSM states: IDLE, CLR, GO, RUN, DONE.
- **IDLE**
  - If any `req` bit is high, pick the first set bit searching upward from the RR pointer, wrapping at NREQ.
  - Latch the owner into `acc_sel` and its `req_len` slice into `acc_n`, then go to CLR.
  - `acc_eoc` is ignored in IDLE.
- **CLR**
  - `gnt[owner]=1` and `acc_clr=1` for this one cycle.
  - If `acc_n==0`, go to DONE with result 0 and `err=0`; no `acc_go` is issued.
  - Otherwise go to GO.
- **GO**
  - `acc_go=1` for this one cycle, timeout counter cleared, then go to RUN.
- **RUN**
  - Counter increments every cycle.
  - If `acc_eoc` is high, capture `acc_sum` into `result`, set `err=0`, go to DONE.
  - If the counter reaches `TIMEOUT`, set `result=0`, set `err=1`, go to DONE.
  - If `acc_eoc` and timeout occur in the same cycle, `acc_eoc` wins.
- **DONE**
  - `done[owner]=1` for one cycle.
  - RR pointer becomes owner+1, modulo NREQ.
  - Go to IDLE.
- A requester drops `req` after seeing `gnt`. The `req` bit of the current owner is not re-sampled until the next IDLE.
- Requests arriving while `busy` is high wait; none are lost while held.

## Timing
- `req` seen in IDLE at edge t gives:
  - `gnt`/`acc_clr` in cycle t+1
  - `acc_go` in cycle t+2
  - RUN from cycle t+3
- `acc_eoc` sampled high at edge e: `done`/`result`/`err` valid in cycle e+1.
- Zero-length job: `done` in cycle t+2.
- Back-to-back jobs: earliest next `gnt` is 2 cycles after `done`, through DONE→IDLE→CLR.
- Timeout: `done` with `err=1` arrives `TIMEOUT` cycles after the first RUN cycle.
- `acc_clr` precedes `acc_go` by one cycle, so a stale `acc_eoc` from the previous job is low by RUN.
- Reset asserted mid-job forces all outputs to 0 immediately. The aborted job gets no `done`; the requester must re-request.

## Test plan
- Single job:
  - Stimulus: after reset, `req[1]=1`, len 4; accelerator model asserts `acc_eoc` with sum 0x1234.
  - Response: `gnt[1]` and `acc_clr` at t+1; `acc_go` at t+2 with `acc_n=4`, `acc_sel=1`; `done[1]` one cycle after `acc_eoc`; `result=0x1234`; `err=0`.
- Fairness:
  - Stimulus: all four `req` held high continuously, each re-asserted after its `done`.
  - Response: grants in order 0,1,2,3,0; no requester is granted twice before the others are served.
- Zero length:
  - Stimulus: `req[2]=1`, len 0.
  - Response: `gnt[2]` at t+1; `done[2]` at t+2 with `result=0`, `err=0`; `acc_go` never asserted.
- Timeout:
  - Stimulus: `acc_eoc` held low, `TIMEOUT=600`.
  - Response: `done[owner]` with `err=1` and `result=0` exactly 600 cycles after RUN entry; next job proceeds normally.
- Reset mid-RUN:
  - Stimulus: assert `rst` during RUN.
  - Response: `busy`, `acc_go` and `done` go to 0 asynchronously. After release with `req[3]` and `req[0]` pending, requester 0 is granted first (pointer reset).
- Stale eoc:
  - Stimulus: `acc_eoc` high in IDLE with no `req`.
  - Response: no `done`, no state change; a following job completes only on its own `acc_eoc`.

Source files
------------

// File: rtl/mac_job_scheduler_if.sv
// Port bundle between the requesters / MAC accelerator and mac_job_scheduler.
// Handshake: requester i raises req[i] with its req_len slice stable and holds
// both until it sees the one-cycle gnt[i] pulse, then drops req[i]. The job ends
// with a one-cycle done[i] pulse; err and result are valid in that same cycle
// and result holds until the next done.
interface mac_job_scheduler_if #(
  parameter int ID_W   = 2,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 16
);
  localparam int NREQ = 1 << ID_W;

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [DATA_W-1:0]     result;
  logic                  busy;
  logic                  acc_clr;
  logic                  acc_go;
  logic [LEN_W-1:0]      acc_n;
  logic [ID_W-1:0]       acc_sel;
  logic                  acc_eoc;
  logic [DATA_W-1:0]     acc_sum;

  // master: requesters plus accelerator; slave: the scheduler itself
  modport master (
    output req, req_len, acc_eoc, acc_sum,
    input  gnt, done, err, result, busy, acc_clr, acc_go, acc_n, acc_sel
  );
  modport slave (
    input  req, req_len, acc_eoc, acc_sum,
    output gnt, done, err, result, busy, acc_clr, acc_go, acc_n, acc_sel
  );
endinterface

// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one pipelined dot-product MAC accelerator among
// NREQ requesters: grant, clear, start, wait for eoc (or timeout), return sum.
// Every output is registered; the output comb computes next values from the
// next state so that each pulse lines up with the state it belongs to.
module mac_job_scheduler #(
  parameter int ID_W    = 2,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 16,
  parameter int TMO_W   = 10,
  parameter int TIMEOUT = 600
) (
  input  logic               clk,
  input  logic               rst,
  mac_job_scheduler_if.slave bus,
  output logic [2:0]         dbg_state
);
  localparam int NREQ = 1 << ID_W;
  localparam logic [NREQ-1:0]  ONE      = NREQ'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_GO   = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic              pick_found;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;

  logic [NREQ-1:0]   gnt_d;
  logic [NREQ-1:0]   done_d;
  logic              err_d;
  logic [DATA_W-1:0] result_d;
  logic              busy_d;
  logic              clr_d;
  logic              go_d;
  logic [LEN_W-1:0]  n_d;
  logic [ID_W-1:0]   sel_d;

  // tmo_cnt is 0 in the first RUN cycle, so TIMEOUT-1 marks the last RUN cycle
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign dbg_state = state;

  // Round-robin search: first pending request at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    cand       = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      cand = rr_ptr + ID_W'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; eoc is only honoured in RUN, where it beats the timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (pick_found) next_state = S_CLR;
      S_CLR:   next_state = (bus.acc_n == '0) ? S_DONE : S_GO;
      S_GO:    next_state = S_RUN;
      S_RUN:   if (bus.acc_eoc || tmo_hit) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output next values, derived from the state being entered.
  always_comb begin
    gnt_d    = '0;
    done_d   = '0;
    clr_d    = 1'b0;
    go_d     = 1'b0;
    busy_d   = (next_state != S_IDLE);
    sel_d    = bus.acc_sel;
    n_d      = bus.acc_n;
    err_d    = bus.err;
    result_d = bus.result;
    if (state == S_IDLE && pick_found) begin
      sel_d = pick_id;
      n_d   = bus.req_len[pick_id*LEN_W +: LEN_W];
    end
    case (next_state)
      S_CLR: begin
        gnt_d = ONE << pick_id;
        clr_d = 1'b1;
      end
      S_GO:    go_d   = 1'b1;
      S_DONE:  done_d = ONE << bus.acc_sel;
      default: ;
    endcase
    if (state == S_RUN && bus.acc_eoc) begin
      result_d = bus.acc_sum;
      err_d    = 1'b0;
    end else if (state == S_RUN && tmo_hit) begin
      result_d = '0;
      err_d    = 1'b1;
    end else if (state == S_CLR && bus.acc_n == '0) begin
      result_d = '0;
      err_d    = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.err     <= 1'b0;
      bus.result  <= '0;
      bus.busy    <= 1'b0;
      bus.acc_clr <= 1'b0;
      bus.acc_go  <= 1'b0;
      bus.acc_n   <= '0;
      bus.acc_sel <= '0;
    end else begin
      bus.gnt     <= gnt_d;
      bus.done    <= done_d;
      bus.err     <= err_d;
      bus.result  <= result_d;
      bus.busy    <= busy_d;
      bus.acc_clr <= clr_d;
      bus.acc_go  <= go_d;
      bus.acc_n   <= n_d;
      bus.acc_sel <= sel_d;
    end
  end

  // Timeout counter (cleared in GO, counts in RUN) and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == S_GO)       tmo_cnt <= '0;
      else if (state == S_RUN) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_DONE)     rr_ptr  <= bus.acc_sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Self-checking bench for mac_job_scheduler: requester driver, accelerator model
// and a round-robin reference that predicts the owner of every grant.
module tb_mac_job_scheduler;
  localparam int ID_W    = 2;
  localparam int LEN_W   = 8;
  localparam int DATA_W  = 16;
  localparam int TMO_W   = 10;
  localparam int TIMEOUT = 600;
  localparam int NREQ    = 1 << ID_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_job_scheduler_if #(.ID_W(ID_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

  mac_job_scheduler #(
    .ID_W(ID_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- reference state / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [NREQ-1:0]   pend = '0;
  int                lens[NREQ];
  int                rr_ref = 0;

  // ---------------- accelerator model ----------------
  int                acc_lat = 2;
  bit                acc_hang = 1'b0;
  bit                force_eoc = 1'b0;
  bit                fixed_sum_en = 1'b0;
  logic [DATA_W-1:0] fixed_sum = '0;
  bit                model_eoc = 1'b0;
  bit                running = 1'b0;
  int                lat_cnt = 0;
  int                eoc_rise_cyc = -10;
  int                go_count = 0;
  logic [DATA_W-1:0] job_sum = '0;

  initial begin : acc_model
    bus.acc_eoc = 1'b0;
    bus.acc_sum = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_eoc = 1'b0;
        running   = 1'b0;
        exp_q.delete();
      end else begin
        if (bus.acc_clr) begin
          model_eoc = 1'b0;
          running   = 1'b0;
        end
        if (bus.acc_go) begin
          running  = 1'b1;
          lat_cnt  = acc_lat;
          job_sum  = fixed_sum_en ? fixed_sum : DATA_W'($urandom);
          go_count = go_count + 1;
        end else if (running && !acc_hang) begin
          if (lat_cnt == 0) begin
            model_eoc    = 1'b1;
            running      = 1'b0;
            bus.acc_sum  = job_sum;
            eoc_rise_cyc = cyc;
            exp_q.push_back(job_sum);
          end else begin
            lat_cnt = lat_cnt - 1;
          end
        end
      end
      bus.acc_eoc = model_eoc | force_eoc;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic int ref_pick(input logic [NREQ-1:0] p, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    if (id >= 0) v[id] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_len(input int id, input int len);
    lens[id] = len;
    bus.req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic wait_gnt(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (|bus.gnt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (|bus.done) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    pend = '0;
    bus.req = '0;
    bus.req_len = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %0h want 0", bus.gnt); end
    checks++; if (bus.done !== '0) begin errors++; $display("FAIL reset_done: got %0h want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result: got %0h want 0", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.acc_clr !== 1'b0 || bus.acc_go !== 1'b0) begin errors++; $display("FAIL reset_clr_go: got %0b%0b want 00", bus.acc_clr, bus.acc_go); end
    checks++; if (bus.acc_n !== '0 || bus.acc_sel !== '0) begin errors++; $display("FAIL reset_n_sel: got %0h/%0h want 0/0", bus.acc_n, bus.acc_sel); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    rr_ref = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    int exp_id, done_cyc;
    bit ok;
    logic [DATA_W-1:0] exp_sum;
    done_cyc = 0;
    for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(1, 6));
    pend = '1;
    bus.req = pend;
    for (int j = 0; j < 5; j++) begin
      acc_lat = $urandom_range(0, 5);
      exp_id = ref_pick(pend, rr_ref);
      wait_gnt(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_gnt_wait: got none want gnt[%0d]", exp_id); end
      checks++; if (bus.gnt !== onehot(exp_id)) begin errors++; $display("FAIL fair_gnt: got %0h want %0h", bus.gnt, onehot(exp_id)); end
      if (j > 0) begin
        checks++; if (cyc !== done_cyc + 2) begin errors++; $display("FAIL fair_b2b_gap: got cycle %0d want %0d", cyc, done_cyc + 2); end
      end
      pend[exp_id] = 1'b0;
      bus.req = pend;
      wait_done(40, ok);
      checks++; if (!ok || bus.done !== onehot(exp_id)) begin errors++; $display("FAIL fair_done: got %0h want %0h", bus.done, onehot(exp_id)); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL fair_result: got %0h want queued sum (none)", bus.result); end
      else begin
        exp_sum = exp_q.pop_front();
        if (bus.result !== exp_sum || bus.err !== 1'b0) begin errors++; $display("FAIL fair_result: got %0h err %0b want %0h err 0", bus.result, bus.err, exp_sum); end
      end
      rr_ref = (exp_id + 1) % NREQ;
      done_cyc = cyc;
      if (j < 4) pend[exp_id] = 1'b1;
      else pend = '0;
      bus.req = pend;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_job();
    bit ok;
    fixed_sum_en = 1'b1;
    fixed_sum = 16'h1234;
    acc_lat = 3;
    set_len(1, 4);
    pend = 4'b0010;
    bus.req = pend;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010 || bus.acc_clr !== 1'b1) begin errors++; $display("FAIL single_gnt_clr: got %0h/%0b want 2/1", bus.gnt, bus.acc_clr); end
    pend = '0;
    bus.req = pend;
    @(negedge clk);
    checks++; if (bus.acc_go !== 1'b1 || bus.acc_n !== 8'd4 || bus.acc_sel !== 2'd1) begin errors++; $display("FAIL single_go: got go %0b n %0d sel %0d want 1/4/1", bus.acc_go, bus.acc_n, bus.acc_sel); end
    wait_done(30, ok);
    checks++; if (!ok || bus.done !== 4'b0010) begin errors++; $display("FAIL single_done: got %0h want 2", bus.done); end
    checks++; if (cyc !== eoc_rise_cyc + 1) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", cyc, eoc_rise_cyc + 1); end
    checks++; if (bus.result !== 16'h1234 || bus.err !== 1'b0) begin errors++; $display("FAIL single_result: got %0h err %0b want 1234 err 0", bus.result, bus.err); end
    exp_q.delete();
    rr_ref = 2;
    @(negedge clk);
    checks++; if (bus.done !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_after: got done %0h busy %0b want 0/0", bus.done, bus.busy); end
    fixed_sum_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_length();
    int go_before;
    go_before = go_count;
    set_len(2, 0);
    pend = 4'b0100;
    bus.req = pend;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL zero_gnt: got %0h want 4", bus.gnt); end
    pend = '0;
    bus.req = pend;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL zero_done: got %0h want 4", bus.done); end
    checks++; if (bus.result !== '0 || bus.err !== 1'b0) begin errors++; $display("FAIL zero_result: got %0h err %0b want 0 err 0", bus.result, bus.err); end
    rr_ref = 3;
    repeat (2) @(negedge clk);
    checks++; if (go_count !== go_before) begin errors++; $display("FAIL zero_no_go: got %0d go pulses want 0", go_count - go_before); end
  endtask

  task automatic test_timeout();
    int g;
    bit ok;
    logic [DATA_W-1:0] exp_sum;
    acc_hang = 1'b1;
    set_len(0, 5);
    pend = 4'b0001;
    bus.req = pend;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL tmo_gnt: got %0h want 1", bus.gnt); end
    pend = '0;
    bus.req = pend;
    @(negedge clk);
    g = cyc;
    wait_done(TIMEOUT + 20, ok);
    checks++; if (!ok || cyc !== g + 1 + TIMEOUT) begin errors++; $display("FAIL tmo_time: got cycle %0d want %0d", cyc, g + 1 + TIMEOUT); end
    checks++; if (bus.done !== 4'b0001 || bus.err !== 1'b1 || bus.result !== '0) begin errors++; $display("FAIL tmo_result: got done %0h err %0b res %0h want 1/1/0", bus.done, bus.err, bus.result); end
    rr_ref = 1;
    acc_hang = 1'b0;
    acc_lat = 2;
    repeat (2) @(negedge clk);
    set_len(1, 3);
    pend = 4'b0010;
    bus.req = pend;
    wait_gnt(10, ok);
    checks++; if (!ok || bus.gnt !== 4'b0010) begin errors++; $display("FAIL tmo_next_gnt: got %0h want 2", bus.gnt); end
    pend = '0;
    bus.req = pend;
    wait_done(30, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL tmo_next_done: got done %0h want 2 with queued sum", bus.done); end
    else begin
      exp_sum = exp_q.pop_front();
      if (bus.done !== 4'b0010 || bus.result !== exp_sum || bus.err !== 1'b0) begin errors++; $display("FAIL tmo_next_done: got %0h/%0h/%0b want 2/%0h/0", bus.done, bus.result, bus.err, exp_sum); end
    end
    rr_ref = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int exp_id;
    bit ok;
    logic [DATA_W-1:0] exp_sum;
    acc_hang = 1'b1;
    set_len(2, 3);
    pend = 4'b0100;
    bus.req = pend;
    wait_gnt(10, ok);
    pend = '0;
    bus.req = pend;
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.acc_sel !== 2'd2) begin errors++; $display("FAIL rmr_running: got busy %0b sel %0d want 1/2", bus.busy, bus.acc_sel); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.acc_go !== 1'b0 || bus.done !== '0) begin errors++; $display("FAIL rmr_async: got busy %0b go %0b done %0h want 0/0/0", bus.busy, bus.acc_go, bus.done); end
    checks++; if (bus.acc_sel !== '0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rmr_state: got sel %0d state %0d want 0/0", bus.acc_sel, dbg_state); end
    acc_hang = 1'b0;
    acc_lat = 1;
    set_len(0, 2);
    set_len(3, 2);
    pend = 4'b1001;
    bus.req = pend;
    @(negedge clk);
    rst = 1'b0;
    rr_ref = 0;
    for (int j = 0; j < 2; j++) begin
      exp_id = ref_pick(pend, rr_ref);
      wait_gnt(10, ok);
      checks++; if (!ok || bus.gnt !== onehot(exp_id)) begin errors++; $display("FAIL rmr_gnt: got %0h want %0h", bus.gnt, onehot(exp_id)); end
      pend[exp_id] = 1'b0;
      bus.req = pend;
      wait_done(30, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL rmr_done: got done %0h want %0h with queued sum", bus.done, onehot(exp_id)); end
      else begin
        exp_sum = exp_q.pop_front();
        if (bus.done !== onehot(exp_id) || bus.result !== exp_sum) begin errors++; $display("FAIL rmr_done: got %0h/%0h want %0h/%0h", bus.done, bus.result, onehot(exp_id), exp_sum); end
      end
      rr_ref = (exp_id + 1) % NREQ;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_eoc();
    bit ok;
    logic [DATA_W-1:0] exp_sum;
    force_eoc = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++; if (bus.done !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stale_idle: got done %0h busy %0b want 0/0", bus.done, bus.busy); end
    end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL stale_state: got %0d want 0", dbg_state); end
    acc_lat = 4;
    set_len(1, 2);
    pend = 4'b0010;
    bus.req = pend;
    wait_gnt(10, ok);
    checks++; if (!ok || bus.gnt !== 4'b0010) begin errors++; $display("FAIL stale_gnt: got %0h want 2", bus.gnt); end
    pend = '0;
    bus.req = pend;
    force_eoc = 1'b0;
    wait_done(30, ok);
    checks++; if (!ok || cyc !== eoc_rise_cyc + 1) begin errors++; $display("FAIL stale_latency: got cycle %0d want %0d", cyc, eoc_rise_cyc + 1); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL stale_result: got %0h want queued sum (none)", bus.result); end
    else begin
      exp_sum = exp_q.pop_front();
      if (bus.done !== 4'b0010 || bus.result !== exp_sum || bus.err !== 1'b0) begin errors++; $display("FAIL stale_result: got %0h/%0h/%0b want 2/%0h/0", bus.done, bus.result, bus.err, exp_sum); end
    end
    rr_ref = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int exp_id, exp_len, done_cyc, gnt_cyc, k;
    bit ok;
    logic [DATA_W-1:0] exp_sum;
    done_cyc = 0;
    pend = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_len(i, $urandom_range(0, 6));
        end
      end
      if (pend == '0) begin
        k = $urandom_range(0, NREQ - 1);
        pend[k] = 1'b1;
        set_len(k, $urandom_range(0, 6));
      end
      bus.req = pend;
      acc_lat = $urandom_range(0, 6);
      exp_id = ref_pick(pend, rr_ref);
      exp_len = lens[exp_id];
      wait_gnt(10, ok);
      gnt_cyc = cyc;
      checks++; if (!ok || bus.gnt !== onehot(exp_id)) begin errors++; $display("FAIL rand_gnt: got %0h want %0h", bus.gnt, onehot(exp_id)); end
      if (j > 0) begin
        checks++; if (gnt_cyc !== done_cyc + 2) begin errors++; $display("FAIL rand_b2b_gap: got cycle %0d want %0d", gnt_cyc, done_cyc + 2); end
      end
      pend[exp_id] = 1'b0;
      bus.req = pend;
      @(negedge clk);
      if (exp_len == 0) begin
        ok = |bus.done;
        checks++; if (bus.done !== onehot(exp_id) || bus.result !== '0 || bus.err !== 1'b0) begin errors++; $display("FAIL rand_zero: got %0h/%0h/%0b want %0h/0/0", bus.done, bus.result, bus.err, onehot(exp_id)); end
      end else begin
        checks++; if (bus.acc_go !== 1'b1 || bus.acc_n !== LEN_W'(exp_len)) begin errors++; $display("FAIL rand_go: got go %0b n %0d want 1/%0d", bus.acc_go, bus.acc_n, exp_len); end
        wait_done(40, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL rand_done: got done %0h want %0h with queued sum", bus.done, onehot(exp_id)); end
        else begin
          exp_sum = exp_q.pop_front();
          if (bus.done !== onehot(exp_id) || bus.result !== exp_sum || bus.err !== 1'b0) begin errors++; $display("FAIL rand_done: got %0h/%0h/%0b want %0h/%0h/0", bus.done, bus.result, bus.err, onehot(exp_id), exp_sum); end
        end
      end
      rr_ref = (exp_id + 1) % NREQ;
      done_cyc = cyc;
    end
    pend = '0;
    bus.req = pend;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fairness();
    test_single_job();
    test_zero_length();
    test_timeout();
    test_reset_mid_run();
    test_stale_eoc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test want finish before 400000");
    $fatal(1, "watchdog expired");
  end
endmodule
